multi_cycle_main_decoder: RTL and testbench
===========================================

// Module: multi_cycle_main_decoder
// PURPOSE
//  Multi-cycle successor to the single-cycle main decoder: Moore FSM sequencing MIPS instructions
//  over several cycles on a shared ULA and one unified memory. Sits in the control path beside
//  the ULA decoder (consumes ULAOp) and drives PC/IR/regfile/memory enables of the datapath.
//  Adds addi/j support, memory wait-state handshake with timeout, illegal-opcode flag.
// PARAMETERS
//  ENABLE_ADDI  1   1: opcode 001000 executes; 0: treated as illegal
//  ENABLE_J     1   1: opcode 000010 executes; 0: treated as illegal
//  MEM_TIMEOUT  16  max cycles waiting MemReady in a memory state; 0 = wait forever
//  TMO_W        5   timeout counter width, >= clog2(MEM_TIMEOUT+1)
// PORTS
//  clk       in   1  rising-edge clock
//  rst_n     in   1  asynchronous active-low reset
//  Opcode    in   6  instruction[31:26] from IR; sampled in DECODE
//  MemReady  in   1  memory completes the access this cycle
//  IorD      out  1  0: address=PC, 1: address=ULAOut
//  MemWrite  out  1  memory write strobe
//  IRWrite   out  1  load instruction register
//  PCWrite   out  1  unconditional PC load
//  Branch    out  1  PC load qualified by ULA zero
//  PCSrc     out  2  00 ULAResult, 01 ULAOut, 10 jump target
//  ULASrcA   out  1  0: PC, 1: rs
//  ULASrcB   out  2  00 rt, 01 const 4, 10 signimm, 11 signimm<<2
//  ULAOp     out  2  00 add, 01 sub, 10 use funct
//  RegDst    out  1  0: rt, 1: rd
//  MemtoReg  out  1  0: ULAOut, 1: memory data
//  RegWrite  out  1  register file write
//  instr_done out 1  1-cycle pulse in last state of each instruction
//  illegal_op out 1  1-cycle pulse: unsupported opcode seen in DECODE
//  mem_err   out  1  1-cycle pulse: memory timeout abort
//  state_o   out  4  current state code (debug)
// BEHAVIOUR
//  - rst_n low: state=S_IDLE, op_q=0, timer=0; all outputs 0. S_IDLE -> FETCH next cycle.
//  - Outputs are combinational of (state, MemReady, op_q); unlisted outputs 0 in every state.
//  - FETCH: IorD0 ULASrcA0 ULASrcB01 ULAOp00 PCSrc00; IRWrite=PCWrite=MemReady.
//    Holds until MemReady=1 -> DECODE.
//  - DECODE: ULASrcB11 ULAOp00 (branch target); op_q<=Opcode. Next: LW/SW->MEMADR,
//    R->EXECUTE, BEQ->BRANCH, ADDI->ADDIEXEC, J->JUMP; other (or disabled) -> FETCH + illegal_op.
//  - MEMADR: ULASrcA1 ULASrcB10 ULAOp00 -> MEMREAD (LW) / MEMWRITE (SW).
//  - MEMREAD: IorD1; hold until MemReady -> MEMWB. MEMWB: MemtoReg1 RegWrite1, done -> FETCH.
//  - MEMWRITE: IorD1 MemWrite1 held while waiting; MemReady -> FETCH, done.
//  - EXECUTE: ULASrcA1 ULASrcB00 ULAOp10 -> ALUWB: RegDst1 RegWrite1, done -> FETCH.
//  - BRANCH: ULASrcA1 ULASrcB00 ULAOp01 PCSrc01 Branch1, done -> FETCH.
//  - ADDIEXEC: ULASrcA1 ULASrcB10 ULAOp00 -> ADDIWB: RegWrite1, done -> FETCH.
//  - JUMP: PCSrc10 PCWrite1, done -> FETCH.
//  - Latency (MemReady always 1): R 4, LW 5, SW 4, BEQ 3, ADDI 4, J 3 cycles.
//  - Timer: cleared on entering FETCH/MEMREAD/MEMWRITE, +1 each waiting cycle (MemReady=0).
//    MEM_TIMEOUT>0 and timer==MEM_TIMEOUT-1 with MemReady=0 -> mem_err, FETCH;
//    no register/PC/IR write that cycle. MemReady and timeout same cycle: MemReady wins.
//  - Counter saturates, never wraps; MEM_TIMEOUT=0 disables compare.
//  - Reset mid-instruction: immediate return to S_IDLE; partial instruction abandoned.
//  - Unused state codes -> S_IDLE next cycle, all outputs 0.
// STRUCTURE
//  - Shared package/include mc_ctrl_defs: 4-bit state codes (S_IDLE=0, FETCH=1, DECODE=2,
//    MEMADR=3, MEMREAD=4, MEMWB=5, MEMWRITE=6, EXECUTE=7, ALUWB=8, BRANCH=9,
//    ADDIEXEC=10, ADDIWB=11, JUMP=12), opcodes (R 000000, LW 100011, SW 101011,
//    BEQ 000100, ADDI 001000, J 000010), ULAOp codes.
//  - One sub-module: mem_wait_timer (clear/enable/expire; MEM_TIMEOUT, TMO_W).
// TESTING
//  - Reset: rst_n=0 mid-MEMWRITE -> same cycle all outputs 0, state_o=0; FETCH 1 cycle after release.
//  - Opcode 100011, MemReady=1 -> states 1,2,3,4,5; RegWrite+MemtoReg only in state 5; done once.
//  - Opcode 101011, MemReady=0 for 3 cycles in MEMWRITE -> MemWrite=1 for 4 cycles, IorD=1.
//  - Opcode 000100 -> BRANCH: ULAOp=01, PCSrc=01, Branch=1; J (000010) -> PCWrite=1, PCSrc=10.
//  - Opcode 111111, and 001000 with ENABLE_ADDI=0 -> DECODE->FETCH, illegal_op=1, no RegWrite.
//  - MEM_TIMEOUT=4, MemReady=0 in FETCH -> mem_err on 4th cycle, IRWrite never 1, re-enter FETCH.

Source files
------------

// File: rtl/mc_ctrl_defs.sv
// Shared definitions for the multi-cycle control path: state codes, opcodes
// and the select/operation codes driven onto the datapath muxes and the ULA.
package mc_ctrl_defs;

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_MEMADR   = 4'd3,
    S_MEMREAD  = 4'd4,
    S_MEMWB    = 4'd5,
    S_MEMWRITE = 4'd6,
    S_EXECUTE  = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_ADDIEXEC = 4'd10,
    S_ADDIWB   = 4'd11,
    S_JUMP     = 4'd12
  } state_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;

  localparam logic [1:0] ULA_ADD   = 2'b00;
  localparam logic [1:0] ULA_SUB   = 2'b01;
  localparam logic [1:0] ULA_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_RT    = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] PCSRC_ULA    = 2'b00;
  localparam logic [1:0] PCSRC_ULAOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // States that wait on the unified memory and are therefore timed.
  function automatic logic is_mem_state(input state_t s);
    return (s == S_FETCH) || (s == S_MEMREAD) || (s == S_MEMWRITE);
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts cycles spent waiting on the memory handshake and flags when the
// wait has reached its limit; the count saturates instead of wrapping.
module mem_wait_timer #(
  parameter int MEM_TIMEOUT = 16,
  parameter int TMO_W       = 5
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam logic [TMO_W-1:0] LIMIT = TMO_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

  logic [TMO_W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != {TMO_W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

  // A zero limit means the memory may stall indefinitely.
  generate
    if (MEM_TIMEOUT > 0) begin : g_cmp
      assign expire = (count == LIMIT);
    end else begin : g_nocmp
      assign expire = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/multi_cycle_main_decoder.sv
// Moore control FSM for the multi-cycle MIPS datapath: walks each instruction
// through fetch/decode/execute/memory/writeback on a shared ULA and memory.
module multi_cycle_main_decoder
  import mc_ctrl_defs::*;
#(
  parameter int ENABLE_ADDI = 1,
  parameter int ENABLE_J    = 1,
  parameter int MEM_TIMEOUT = 16,
  parameter int TMO_W       = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] Opcode,
  input  logic       MemReady,
  output logic       IorD,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic       Branch,
  output logic [1:0] PCSrc,
  output logic       ULASrcA,
  output logic [1:0] ULASrcB,
  output logic [1:0] ULAOp,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic       instr_done,
  output logic       illegal_op,
  output logic       mem_err,
  output logic [3:0] state_o
);

  state_t     state;
  state_t     next_state;
  logic [5:0] op_q;
  logic       expire;
  logic       waiting;
  logic       timeout;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      op_q  <= '0;
    end else begin
      state <= next_state;
      if (state == S_DECODE) begin
        op_q <= Opcode;
      end
    end
  end

  // The timer restarts from zero whenever a memory state is (re)entered.
  assign timeout = is_mem_state(state) && !MemReady && expire;
  assign waiting = is_mem_state(state) && !MemReady && !expire;

  mem_wait_timer #(
    .MEM_TIMEOUT(MEM_TIMEOUT),
    .TMO_W      (TMO_W)
  ) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (!waiting),
    .enable(waiting),
    .expire(expire)
  );

  assign mem_err = timeout;
  assign state_o = state;

  always_comb begin
    next_state = S_IDLE;
    IorD       = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    PCWrite    = 1'b0;
    Branch     = 1'b0;
    PCSrc      = PCSRC_ULA;
    ULASrcA    = 1'b0;
    ULASrcB    = SRCB_RT;
    ULAOp      = ULA_ADD;
    RegDst     = 1'b0;
    MemtoReg   = 1'b0;
    RegWrite   = 1'b0;
    instr_done = 1'b0;
    illegal_op = 1'b0;

    case (state)
      S_IDLE: next_state = S_FETCH;

      S_FETCH: begin
        ULASrcB    = SRCB_FOUR;
        IRWrite    = MemReady;
        PCWrite    = MemReady;
        next_state = MemReady ? S_DECODE : S_FETCH;
      end

      // Branch target is computed speculatively while the opcode is decoded.
      S_DECODE: begin
        ULASrcB = SRCB_IMMSH;
        case (Opcode)
          OP_LW, OP_SW: next_state = S_MEMADR;
          OP_R:         next_state = S_EXECUTE;
          OP_BEQ:       next_state = S_BRANCH;
          OP_ADDI: begin
            if (ENABLE_ADDI != 0) begin
              next_state = S_ADDIEXEC;
            end else begin
              next_state = S_FETCH;
              illegal_op = 1'b1;
            end
          end
          OP_J: begin
            if (ENABLE_J != 0) begin
              next_state = S_JUMP;
            end else begin
              next_state = S_FETCH;
              illegal_op = 1'b1;
            end
          end
          default: begin
            next_state = S_FETCH;
            illegal_op = 1'b1;
          end
        endcase
      end

      S_MEMADR: begin
        ULASrcA    = 1'b1;
        ULASrcB    = SRCB_IMM;
        next_state = (op_q == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      end

      S_MEMREAD: begin
        IorD = 1'b1;
        if (MemReady)     next_state = S_MEMWB;
        else if (timeout) next_state = S_FETCH;
        else              next_state = S_MEMREAD;
      end

      S_MEMWB: begin
        MemtoReg   = 1'b1;
        RegWrite   = 1'b1;
        instr_done = 1'b1;
        next_state = S_FETCH;
      end

      S_MEMWRITE: begin
        IorD       = 1'b1;
        MemWrite   = 1'b1;
        instr_done = MemReady;
        if (MemReady || timeout) next_state = S_FETCH;
        else                     next_state = S_MEMWRITE;
      end

      S_EXECUTE: begin
        ULASrcA    = 1'b1;
        ULASrcB    = SRCB_RT;
        ULAOp      = ULA_FUNCT;
        next_state = S_ALUWB;
      end

      S_ALUWB: begin
        RegDst     = 1'b1;
        RegWrite   = 1'b1;
        instr_done = 1'b1;
        next_state = S_FETCH;
      end

      S_BRANCH: begin
        ULASrcA    = 1'b1;
        ULASrcB    = SRCB_RT;
        ULAOp      = ULA_SUB;
        PCSrc      = PCSRC_ULAOUT;
        Branch     = 1'b1;
        instr_done = 1'b1;
        next_state = S_FETCH;
      end

      S_ADDIEXEC: begin
        ULASrcA    = 1'b1;
        ULASrcB    = SRCB_IMM;
        next_state = S_ADDIWB;
      end

      S_ADDIWB: begin
        RegWrite   = 1'b1;
        instr_done = 1'b1;
        next_state = S_FETCH;
      end

      S_JUMP: begin
        PCSrc      = PCSRC_JUMP;
        PCWrite    = 1'b1;
        instr_done = 1'b1;
        next_state = S_FETCH;
      end

      default: next_state = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_multi_cycle_main_decoder.sv
// Bench for the multi-cycle main decoder: opcode table, directed multi-cycle
// corner cases, and a randomized run against an instruction-level model.
module tb_multi_cycle_main_decoder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] Opcode, op2;
  logic       MemReady, mr2;

  logic       IorD, MemWrite, IRWrite, PCWrite, Branch, ULASrcA, RegDst, MemtoReg, RegWrite;
  logic [1:0] PCSrc, ULASrcB, ULAOp;
  logic       instr_done, illegal_op, mem_err;
  logic [3:0] state_o;

  logic       IorD2, MemWrite2, IRWrite2, PCWrite2, Branch2, ULASrcA2, RegDst2, MemtoReg2, RegWrite2;
  logic [1:0] PCSrc2, ULASrcB2, ULAOp2;
  logic       instr_done2, illegal_op2, mem_err2;
  logic [3:0] state_o2;

  logic [17:0] outs, outs2;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  multi_cycle_main_decoder dut (
    .clk(clk), .rst_n(rst_n), .Opcode(Opcode), .MemReady(MemReady),
    .IorD(IorD), .MemWrite(MemWrite), .IRWrite(IRWrite), .PCWrite(PCWrite),
    .Branch(Branch), .PCSrc(PCSrc), .ULASrcA(ULASrcA), .ULASrcB(ULASrcB),
    .ULAOp(ULAOp), .RegDst(RegDst), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
    .instr_done(instr_done), .illegal_op(illegal_op), .mem_err(mem_err),
    .state_o(state_o)
  );

  // Second instance: addi disabled and a short memory timeout.
  multi_cycle_main_decoder #(
    .ENABLE_ADDI(0), .ENABLE_J(1), .MEM_TIMEOUT(4), .TMO_W(3)
  ) dut2 (
    .clk(clk), .rst_n(rst_n), .Opcode(op2), .MemReady(mr2),
    .IorD(IorD2), .MemWrite(MemWrite2), .IRWrite(IRWrite2), .PCWrite(PCWrite2),
    .Branch(Branch2), .PCSrc(PCSrc2), .ULASrcA(ULASrcA2), .ULASrcB(ULASrcB2),
    .ULAOp(ULAOp2), .RegDst(RegDst2), .MemtoReg(MemtoReg2), .RegWrite(RegWrite2),
    .instr_done(instr_done2), .illegal_op(illegal_op2), .mem_err(mem_err2),
    .state_o(state_o2)
  );

  assign outs  = {IorD, MemWrite, IRWrite, PCWrite, Branch, PCSrc, ULASrcA, ULASrcB,
                  ULAOp, RegDst, MemtoReg, RegWrite, instr_done, illegal_op, mem_err};
  assign outs2 = {IorD2, MemWrite2, IRWrite2, PCWrite2, Branch2, PCSrc2, ULASrcA2, ULASrcB2,
                  ULAOp2, RegDst2, MemtoReg2, RegWrite2, instr_done2, illegal_op2, mem_err2};

  typedef struct {
    logic [5:0] opcode;
    int         cycles;
    int         illegal;
    int         regwr;
    int         memwr;
    int         branch;
    int         jump;
  } vec_t;

  vec_t vec[7];

  // Instruction-level model: current state plus the states still to visit.
  int mCur;
  int mWait;
  int plan[$];

  task automatic applyStimulus(input logic [5:0] op, input logic mr,
                               input logic [5:0] opb, input logic mrb);
    @(negedge clk);
    Opcode   = op;
    MemReady = mr;
    op2      = opb;
    mr2      = mrb;
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  function automatic bit is_mem(input int s);
    return (s == 1) || (s == 4) || (s == 6);
  endfunction

  function automatic bit spec_legal(input logic [5:0] op);
    return (op == 6'd0) || (op == 6'd35) || (op == 6'd43) || (op == 6'd4) ||
           (op == 6'd8) || (op == 6'd2);
  endfunction

  // Expected control word for a state, straight from the per-state listing.
  function automatic logic [17:0] spec_outputs(input int st, input logic mr,
                                               input logic ill, input logic tmo);
    logic iord, mw, irw, pcw, br, srca, rd, m2r, rw, done;
    logic [1:0] pcsrc, srcb, ulaop;
    {iord, mw, irw, pcw, br, srca, rd, m2r, rw, done} = '0;
    pcsrc = 2'b00; srcb = 2'b00; ulaop = 2'b00;
    case (st)
      1:  begin srcb = 2'b01; irw = mr; pcw = mr; end
      2:  srcb = 2'b11;
      3:  begin srca = 1'b1; srcb = 2'b10; end
      4:  iord = 1'b1;
      5:  begin m2r = 1'b1; rw = 1'b1; done = 1'b1; end
      6:  begin iord = 1'b1; mw = 1'b1; done = mr; end
      7:  begin srca = 1'b1; ulaop = 2'b10; end
      8:  begin rd = 1'b1; rw = 1'b1; done = 1'b1; end
      9:  begin srca = 1'b1; ulaop = 2'b01; pcsrc = 2'b01; br = 1'b1; done = 1'b1; end
      10: begin srca = 1'b1; srcb = 2'b10; end
      11: begin rw = 1'b1; done = 1'b1; end
      12: begin pcsrc = 2'b10; pcw = 1'b1; done = 1'b1; end
      default: ;
    endcase
    return {iord, mw, irw, pcw, br, pcsrc, srca, srcb, ulaop, rd, m2r, rw, done,
            (st == 2) && ill, tmo};
  endfunction

  task automatic modelAdvance(input logic [5:0] op, input logic mr, input logic tmo);
    if (is_mem(mCur) && !mr && !tmo) begin
      if (mWait < 31) mWait++;
      return;
    end
    mWait = 0;
    if (tmo) begin
      plan.delete();
      mCur = 1;
      return;
    end
    if (mCur == 1) begin
      mCur = 2;
    end else begin
      if (mCur == 2) begin
        plan.delete();
        case (op)
          6'd0:  plan = {7, 8};
          6'd35: plan = {3, 4, 5};
          6'd43: plan = {3, 6};
          6'd4:  plan = {9};
          6'd8:  plan = {10, 11};
          6'd2:  plan = {12};
          default: ;
        endcase
      end
      if (plan.size() > 0) mCur = plan.pop_front();
      else                 mCur = 1;
    end
  endtask

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: time limit reached before completion");
    $fatal(1);
  end

  initial begin
    int cyc, rw, mwc, brc, jc, ill, dones, stall;
    bit fin;
    logic [5:0] rop;
    logic rmr, tmo;
    int lwStates[5];

    vec[0] = '{6'b000000, 4, 0, 1, 0, 0, 0};
    vec[1] = '{6'b100011, 5, 0, 1, 0, 0, 0};
    vec[2] = '{6'b101011, 4, 0, 0, 1, 0, 0};
    vec[3] = '{6'b000100, 3, 0, 0, 0, 1, 0};
    vec[4] = '{6'b001000, 4, 0, 1, 0, 0, 0};
    vec[5] = '{6'b000010, 3, 0, 0, 0, 0, 1};
    vec[6] = '{6'b111111, 2, 1, 0, 0, 0, 0};
    lwStates = '{1, 2, 3, 4, 5};

    rst_n = 1'b0; Opcode = '0; MemReady = 1'b0; op2 = '0; mr2 = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checkOutput("reset_state", state_o, 0);
    checkOutput("reset_outs", outs, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Opcode table, MemReady held high
    for (int t = 0; t < 7; t++) begin
      cyc = 0; rw = 0; mwc = 0; brc = 0; jc = 0; ill = 0; fin = 0;
      while (!fin && cyc < 12) begin
        applyStimulus(vec[t].opcode, 1'b1, 6'd0, 1'b0);
        cyc++;
        rw  += int'(RegWrite);
        mwc += int'(MemWrite);
        brc += int'(Branch);
        jc  += int'(PCWrite && (PCSrc == 2'b10));
        ill += int'(illegal_op);
        if (instr_done || illegal_op) fin = 1;
      end
      checkOutput($sformatf("tbl%0d_cycles", t), cyc, vec[t].cycles);
      checkOutput($sformatf("tbl%0d_illegal", t), ill, vec[t].illegal);
      checkOutput($sformatf("tbl%0d_regwrite", t), rw, vec[t].regwr);
      checkOutput($sformatf("tbl%0d_memwrite", t), mwc, vec[t].memwr);
      checkOutput($sformatf("tbl%0d_branch", t), brc, vec[t].branch);
      checkOutput($sformatf("tbl%0d_jump", t), jc, vec[t].jump);
    end

    // LW walk through every state
    dones = 0;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(6'b100011, 1'b1, 6'd0, 1'b0);
      checkOutput($sformatf("lw_state%0d", i), state_o, lwStates[i]);
      checkOutput($sformatf("lw_wb%0d", i), {RegWrite, MemtoReg}, (i == 4) ? 2'b11 : 2'b00);
      dones += int'(instr_done);
    end
    checkOutput("lw_done_once", dones, 1);

    // SW with three wait cycles in MEMWRITE
    repeat (3) applyStimulus(6'b101011, 1'b1, 6'd0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(6'b101011, (i == 3), 6'd0, 1'b0);
      checkOutput($sformatf("sw_state%0d", i), state_o, 6);
      checkOutput($sformatf("sw_memwrite%0d", i), {MemWrite, IorD}, 2'b11);
      checkOutput($sformatf("sw_done%0d", i), instr_done, (i == 3));
    end

    // BEQ and J control words
    repeat (2) applyStimulus(6'b000100, 1'b1, 6'd0, 1'b0);
    applyStimulus(6'b000100, 1'b1, 6'd0, 1'b0);
    checkOutput("beq_state", state_o, 9);
    checkOutput("beq_ctrl", {ULAOp, PCSrc, Branch}, 5'b01_01_1);
    repeat (2) applyStimulus(6'b000010, 1'b1, 6'd0, 1'b0);
    applyStimulus(6'b000010, 1'b1, 6'd0, 1'b0);
    checkOutput("j_state", state_o, 12);
    checkOutput("j_ctrl", {PCWrite, PCSrc}, 3'b1_10);

    // Unsupported opcode
    applyStimulus(6'b111111, 1'b1, 6'd0, 1'b0);
    applyStimulus(6'b111111, 1'b1, 6'd0, 1'b0);
    checkOutput("ill_decode", state_o, 2);
    checkOutput("ill_flag", {illegal_op, RegWrite}, 2'b10);
    applyStimulus(6'b111111, 1'b0, 6'd0, 1'b0);
    checkOutput("ill_back_fetch", state_o, 1);
    checkOutput("ill_no_irwrite", IRWrite, 0);

    // Reset asserted in the middle of a store
    repeat (3) applyStimulus(6'b101011, 1'b1, 6'd0, 1'b0);
    applyStimulus(6'b101011, 1'b0, 6'd0, 1'b0);
    checkOutput("rst_pre_state", state_o, 6);
    checkOutput("rst_pre_memwrite", MemWrite, 1);
    rst_n = 1'b0;
    #1;
    checkOutput("rst_async_state", state_o, 0);
    checkOutput("rst_async_outs", outs, 0);
    checkOutput("rst_async_outs2", outs2, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput("rst_release_idle", state_o, 0);

    // Timeout of four cycles in FETCH on the second instance
    for (int i = 1; i <= 4; i++) begin
      applyStimulus(6'b101011, 1'b1, 6'd0, 1'b0);
      if (i == 1) checkOutput("rst_fetch_after_release", state_o, 1);
      checkOutput($sformatf("tmo_state%0d", i), state_o2, 1);
      checkOutput($sformatf("tmo_err%0d", i), mem_err2, (i == 4));
      checkOutput($sformatf("tmo_irwrite%0d", i), IRWrite2, 0);
    end
    applyStimulus(6'b101011, 1'b1, 6'b001000, 1'b1);
    checkOutput("tmo_refetch_state", state_o2, 1);
    checkOutput("tmo_refetch_ctrl", {mem_err2, IRWrite2}, 2'b01);
    applyStimulus(6'b101011, 1'b1, 6'b001000, 1'b1);
    checkOutput("addi_off_decode", state_o2, 2);
    checkOutput("addi_off_flag", {illegal_op2, RegWrite2}, 2'b10);
    applyStimulus(6'b101011, 1'b1, 6'b001000, 1'b0);
    checkOutput("addi_off_fetch", state_o2, 1);

    // Randomized run against the model
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    mCur = 0; mWait = 0; plan.delete();
    checkOutput("rand_idle", state_o, 0);
    modelAdvance(6'd0, 1'b1, 1'b0);
    stall = 0;
    for (int c = 0; c < 600; c++) begin
      case ($urandom_range(0, 7))
        0: rop = 6'd0;
        1: rop = 6'd35;
        2: rop = 6'd43;
        3: rop = 6'd4;
        4: rop = 6'd8;
        5: rop = 6'd2;
        default: rop = 6'($urandom_range(0, 63));
      endcase
      if (stall > 0) begin
        rmr = 1'b0;
        stall--;
      end else begin
        rmr = ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 59) == 0) stall = 18;
      end
      applyStimulus(rop, rmr, 6'd0, 1'b0);
      tmo = is_mem(mCur) && !rmr && (mWait == 15);
      checkOutput($sformatf("rand_state@%0d", c), state_o, mCur);
      checkOutput($sformatf("rand_outs@%0d", c), outs, spec_outputs(mCur, rmr, !spec_legal(rop), tmo));
      modelAdvance(rop, rmr, tmo);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
